// File: rtl/image_line_sequencer.sv
// Feeds image lines from a pixel source into a line-buffered filter, pacing lines on the
// filter's line-free interrupt, appending pad lines and waiting for all filter results.
module image_line_sequencer #(
    parameter int DATA_W      = 8,
    parameter int IMG_WIDTH   = 512,
    parameter int IMG_HEIGHT  = 512,
    parameter int PRIME_LINES = 4,
    parameter int PAD_LINES   = 2,
    parameter int PAD_VALUE   = 0
) (
    input  logic              axi_clk,
    input  logic              axi_reset,
    input  logic              i_start,
    input  logic              i_pix_valid,
    input  logic [DATA_W-1:0] i_pix,
    output logic              o_pix_ready,
    output logic              o_data_valid,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_data_ready,
    input  logic              i_intr,
    input  logic              i_res_valid,
    output logic              o_busy,
    output logic              o_done
);

    localparam int TOTAL  = IMG_WIDTH * IMG_HEIGHT;
    localparam int PIX_W  = $clog2(IMG_WIDTH);
    localparam int LINE_W = $clog2(IMG_HEIGHT + 1);
    localparam int PAD_W  = (PAD_LINES < 1) ? 1 : $clog2(PAD_LINES + 1);
    localparam int RES_W  = $clog2(TOTAL + 1);

    typedef enum logic [2:0] {
        IDLE, PRIME, WAIT_INTR, LINE, PAD_WAIT, PAD, DRAIN, DONE
    } state_t;

    state_t            state;
    logic [PIX_W-1:0]  pix_cnt;
    logic [LINE_W-1:0] line_cnt;
    logic [PAD_W-1:0]  pad_cnt;
    logic [RES_W-1:0]  res_cnt;
    logic              intr_q;
    logic              pend;

    logic              xfer;
    logic              line_end;
    logic              intr_edge;
    logic              wake;
    logic              counting;
    logic              res_reach;
    logic [LINE_W-1:0] line_inc;
    logic [PAD_W-1:0]  pad_inc;

    // Source-to-filter path is a zero-latency pass-through while image lines flow.
    always_comb begin
        o_data_valid = 1'b0;
        o_pix_ready  = 1'b0;
        o_data       = '0;
        case (state)
            PRIME, LINE: begin
                o_data       = i_pix;
                o_data_valid = i_pix_valid;
                o_pix_ready  = i_data_ready;
            end
            PAD: begin
                o_data       = DATA_W'(PAD_VALUE);
                o_data_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign xfer      = o_data_valid && i_data_ready;
    assign line_end  = xfer && (pix_cnt == PIX_W'(IMG_WIDTH - 1));
    assign intr_edge = i_intr && !intr_q;
    assign wake      = intr_edge || pend;
    assign counting  = (state != IDLE) && (state != DONE);
    assign line_inc  = line_cnt + LINE_W'(1);
    assign pad_inc   = pad_cnt + PAD_W'(1);

    // Result count reached now, including a result arriving this very cycle.
    assign res_reach = (res_cnt == RES_W'(TOTAL)) ||
                       (counting && i_res_valid && (res_cnt == RES_W'(TOTAL - 1)));

    assign o_busy = counting;
    assign o_done = (state == DONE);

    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            state    <= IDLE;
            pix_cnt  <= '0;
            line_cnt <= '0;
            pad_cnt  <= '0;
            res_cnt  <= '0;
            pend     <= 1'b0;
            intr_q   <= 1'b1;
        end else begin
            intr_q <= i_intr;

            if (counting && i_res_valid && (res_cnt != RES_W'(TOTAL)))
                res_cnt <= res_cnt + RES_W'(1);

            if (xfer)
                pix_cnt <= line_end ? '0 : pix_cnt + PIX_W'(1);

            if (intr_edge && !pend && (state == PRIME || state == LINE || state == PAD))
                pend <= 1'b1;

            case (state)
                IDLE, DONE: begin
                    if (i_start) begin
                        state    <= PRIME;
                        pix_cnt  <= '0;
                        line_cnt <= '0;
                        pad_cnt  <= '0;
                        res_cnt  <= '0;
                        pend     <= 1'b0;
                    end
                end
                PRIME: begin
                    if (line_end) begin
                        line_cnt <= line_inc;
                        if (line_inc == LINE_W'(PRIME_LINES))
                            state <= (line_inc == LINE_W'(IMG_HEIGHT)) ? PAD_WAIT : WAIT_INTR;
                    end
                end
                WAIT_INTR: begin
                    if (wake) begin
                        state <= LINE;
                        pend  <= 1'b0;
                    end
                end
                LINE: begin
                    if (line_end) begin
                        line_cnt <= line_inc;
                        state    <= (line_inc == LINE_W'(IMG_HEIGHT)) ? PAD_WAIT : WAIT_INTR;
                    end
                end
                PAD_WAIT: begin
                    if (PAD_LINES == 0) begin
                        state <= res_reach ? DONE : DRAIN;
                    end else if (wake) begin
                        state <= PAD;
                        pend  <= 1'b0;
                    end
                end
                PAD: begin
                    if (line_end) begin
                        pad_cnt <= pad_inc;
                        if (pad_inc == PAD_W'(PAD_LINES))
                            state <= res_reach ? DONE : DRAIN;
                        else
                            state <= PAD_WAIT;
                    end
                end
                DRAIN: begin
                    if (res_reach)
                        state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/image_line_sequencer.md
IMAGE_LINE_SEQUENCER -- requirements
Module: image_line_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, 8, pixel width in bits.
REQ-002 SHALL have parameter IMG_WIDTH, 512, pixels per line (>=2).
REQ-003 SHALL have parameter IMG_HEIGHT, 512, image lines (>=PRIME_LINES).
REQ-004 SHALL have parameter PRIME_LINES, 4, lines sent before the first interrupt wait (>=1).
REQ-005 SHALL have parameter PAD_LINES, 2, trailing pad lines (>=0).
REQ-006 SHALL have parameter PAD_VALUE, 0, pixel value of pad lines.
REQ-007 SHALL have port axi_clk, in, 1, the only clock.
REQ-008 SHALL have port axi_reset, in, 1, synchronous active-high reset.
REQ-009 SHALL have port i_start, in, 1, one-cycle pulse starting a frame.
REQ-010 SHALL have port i_pix_valid, in, 1, source pixel valid.
REQ-011 SHALL have port i_pix, in, DATA_W, source pixel.
REQ-012 SHALL have port o_pix_ready, out, 1, source pixel accepted.
REQ-013 SHALL have port o_data_valid, out, 1, pixel valid to filter.
REQ-014 SHALL have port o_data, out, DATA_W, pixel to filter.
REQ-015 SHALL have port i_data_ready, in, 1, filter accepts pixel.
REQ-016 SHALL have port i_intr, in, 1, filter line-free interrupt (level; rising edge significant).
REQ-017 SHALL have port i_res_valid, in, 1, filter output pixel valid (counted, not stored).
REQ-018 SHALL have ports o_busy, out, 1, and o_done, out, 1, frame status.

Function
REQ-019 SHALL implement states IDLE, PRIME, WAIT_INTR, LINE, PAD_WAIT, PAD, DRAIN, DONE.
REQ-020 SHALL count a transfer only when o_data_valid && i_data_ready in the same cycle.
REQ-021 SHALL, in PRIME and LINE, drive o_data=i_pix, o_data_valid=i_pix_valid, o_pix_ready=i_data_ready (combinational pass-through, zero latency).
REQ-022 SHALL, in PAD, drive o_data=PAD_VALUE, o_data_valid=1, o_pix_ready=0.
REQ-023 SHALL, in all other states, drive o_data_valid=0, o_pix_ready=0, o_data=0.
REQ-024 SHALL keep a pixel counter 0..IMG_WIDTH-1 wrapping to 0 on the last pixel of a line, and a line counter incremented on that wrap.
REQ-025 SHALL transition IDLE->PRIME on i_start; i_start in any other state is ignored.
REQ-026 SHALL leave PRIME after PRIME_LINES*IMG_WIDTH transfers: to PAD_WAIT if lines sent == IMG_HEIGHT, else WAIT_INTR.
REQ-027 SHALL leave LINE after IMG_WIDTH transfers: to PAD_WAIT if lines sent == IMG_HEIGHT, else WAIT_INTR.
REQ-028 SHALL detect intr edge as i_intr && !intr_q, intr_q registered every cycle.
REQ-029 SHALL latch an intr edge arriving in PRIME, LINE or PAD into a one-deep pending flag; further edges while pending set are dropped.
REQ-030 SHALL leave WAIT_INTR for LINE, and PAD_WAIT for PAD (or DRAIN if PAD_LINES==0, no intr needed), on an edge or pending flag, clearing the flag.
REQ-031 SHALL leave PAD after PAD_LINES complete pad lines; PAD_LINES>1 SHALL return to PAD_WAIT between pad lines.
REQ-032 SHALL count i_res_valid cycles from PRIME entry until DONE; DRAIN->DONE when count reaches IMG_WIDTH*IMG_HEIGHT, also checked in PAD/PAD_WAIT (reaching it there goes to DONE after pad lines finish).
REQ-033 SHALL assert o_busy in every state except IDLE and DONE; o_done high only in DONE.
REQ-034 SHALL leave DONE to PRIME on i_start (new frame, counters cleared), otherwise hold.
REQ-035 SHALL size counters with $clog2 of their maximum +1; no overflow for legal parameters.

Reset
REQ-036 SHALL, on axi_reset in any state, go to IDLE next cycle, clear all counters and pending flag, set intr_q=1 (no spurious edge if i_intr high out of reset).
REQ-037 SHALL, during and after reset until i_start, hold o_busy=0, o_done=0, o_data_valid=0, o_pix_ready=0, o_data=0.

Verification (W=4,H=6,PRIME=4,PAD=2,PAD_VALUE=0xAA)
REQ-038 Start, source always valid, ready=1 -> 16 transfers back-to-back, then o_data_valid=0 in WAIT_INTR.
REQ-039 Two intr pulses -> two 4-pixel lines, then PAD_WAIT; two more -> eight pixels 0xAA, o_pix_ready=0 throughout.
REQ-040 i_data_ready toggling 1/0 in LINE -> each pixel held stable until accepted, exactly 4 transfers, no source pixel lost.
REQ-041 Intr pulse during PRIME -> after PRIME immediately enters LINE without new edge; second pulse during PRIME -> dropped.
REQ-042 24 i_res_valid cycles after pad lines -> o_done=1, o_busy=0; i_start -> new frame from PRIME.
REQ-043 axi_reset mid-LINE -> next cycle IDLE, outputs zero; i_intr high through reset -> no LINE entry after restart until a new edge.
